// File: rtl/stage3_hazard_controller.sv
// Stall / bubble / flush / forward-select sequencing between E and M of a
// 3-stage pipeline, with a free-running stall-cycle counter.
module stage3_hazard_controller #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             valid_e,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic             rs1_used_e,
  input  logic             rs2_used_e,
  input  logic             mdu_start_e,
  input  logic             mdu_done,
  input  logic             flush_req,
  input  logic             valid_m,
  input  logic [4:0]       rd_m,
  input  logic             reg_write_m,
  input  logic             load_m,
  input  logic             mem_op_m,
  input  logic             dmem_done,
  input  logic             imem_busy,
  output logic             stall_fe,
  output logic             stall_m,
  output logic             bubble_m,
  output logic             flush_fe,
  output logic             fwd_rs1,
  output logic             fwd_rs2,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MDU_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [1:0][4:0] rs_e;
  logic [1:0]      rs_used;
  logic [1:0]      hit;
  logic [1:0]      fwd_raw;
  logic            memstall;
  logic            loaduse;

  assign rs_e    = {rs2_e, rs1_e};
  assign rs_used = {rs2_used_e, rs1_used_e};

  // x0 is hard-wired zero, so a write to it is never a real producer.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hit
      assign hit[gi] = valid_m & reg_write_m & (rd_m != 5'd0) & valid_e &
                       rs_used[gi] & (rs_e[gi] == rd_m);
      assign fwd_raw[gi] = hit[gi] & (~load_m | dmem_done);
    end
  endgenerate

  assign memstall = valid_m & mem_op_m & ~dmem_done;
  assign loaduse  = (|hit) & load_m & ~dmem_done;

  logic stall_fe_c, stall_m_c, bubble_m_c, flush_fe_c;

  always_comb begin
    state_d    = state_q;
    stall_fe_c = 1'b0;
    stall_m_c  = 1'b0;
    bubble_m_c = 1'b0;
    flush_fe_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (memstall) begin
          stall_fe_c = 1'b1;
          stall_m_c  = 1'b1;
          state_d    = ST_MEM_WAIT;
        end else if (mdu_start_e && valid_e) begin
          stall_fe_c = 1'b1;
          bubble_m_c = 1'b1;
          state_d    = ST_MDU_WAIT;
        end else if (loaduse) begin
          stall_fe_c = 1'b1;
          bubble_m_c = 1'b1;
        end else if (flush_req && valid_e) begin
          flush_fe_c = 1'b1;
          state_d    = imem_busy ? ST_FLUSH : ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_done) begin
          state_d = ST_RUN;
        end else begin
          stall_fe_c = 1'b1;
          stall_m_c  = 1'b1;
        end
      end
      ST_MDU_WAIT: begin
        // The MDU result still needs the empty M slot on the completion cycle.
        bubble_m_c = 1'b1;
        if (mdu_done) begin
          state_d = ST_RUN;
        end else begin
          stall_fe_c = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Keep killing F until the stale fetch has drained.
        flush_fe_c = 1'b1;
        if (!imem_busy) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign stall_cnt_d = stall_fe_c ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_fe     = stall_fe_c & ~RST;
  assign stall_m      = stall_m_c  & ~RST;
  assign bubble_m     = bubble_m_c & ~RST;
  assign flush_fe     = flush_fe_c & ~RST;
  assign fwd_rs1      = fwd_raw[0] & ~RST;
  assign fwd_rs2      = fwd_raw[1] & ~RST;
  assign stall_cycles = stall_cnt_q;
  assign state        = state_q;

endmodule

// File: tb/tb_stage3_hazard_controller.sv
// Directed bench for stage3_hazard_controller; outputs are sampled 1-2 ns
// after the rising edge, inputs are driven just after the edge.
module tb_stage3_hazard_controller;

  logic       CLK = 1'b0;
  logic       RST;
  logic       valid_e, rs1_used_e, rs2_used_e, mdu_start_e, mdu_done, flush_req;
  logic [4:0] rs1_e, rs2_e, rd_m;
  logic       valid_m, reg_write_m, load_m, mem_op_m, dmem_done, imem_busy;
  logic       stall_fe, stall_m, bubble_m, flush_fe, fwd_rs1, fwd_rs2;
  logic [3:0] stall_cycles;
  logic [1:0] state;
  logic [7:0] outs;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  stage3_hazard_controller #(.CNT_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .valid_e(valid_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rs1_used_e(rs1_used_e), .rs2_used_e(rs2_used_e),
    .mdu_start_e(mdu_start_e), .mdu_done(mdu_done), .flush_req(flush_req),
    .valid_m(valid_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .load_m(load_m), .mem_op_m(mem_op_m), .dmem_done(dmem_done),
    .imem_busy(imem_busy),
    .stall_fe(stall_fe), .stall_m(stall_m), .bubble_m(bubble_m),
    .flush_fe(flush_fe), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .stall_cycles(stall_cycles), .state(state)
  );

  // {stall_fe, stall_m, bubble_m, flush_fe, fwd_rs1, fwd_rs2, state[1:0]}
  assign outs = {stall_fe, stall_m, bubble_m, flush_fe, fwd_rs1, fwd_rs2, state};

  task automatic clear_inputs();
    valid_e = 0; rs1_e = 0; rs2_e = 0; rs1_used_e = 0; rs2_used_e = 0;
    mdu_start_e = 0; mdu_done = 0; flush_req = 0;
    valid_m = 0; rd_m = 0; reg_write_m = 0; load_m = 0; mem_op_m = 0;
    dmem_done = 0; imem_busy = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    RST = 1'b1;
    valid_m = 1; mem_op_m = 1; valid_e = 1; mdu_start_e = 1;
    valid_e = 1; rs1_e = 3; rs1_used_e = 1; rd_m = 3; reg_write_m = 1;
    #1;
    checks++;
    if (outs !== 8'b0000_0000) begin
      failures++;
      $display("FAIL reset_outs outs=%b expected=%b", outs, 8'b0000_0000);
    end
    tick();
    checks++;
    if (stall_cycles !== 4'd0) begin
      failures++;
      $display("FAIL reset_cnt stall_cycles=%0d expected=0", stall_cycles);
    end
    $display("test_reset outs=%b stall_cycles=%0d", outs, stall_cycles);
    RST = 1'b0;
    clear_inputs();
  endtask

  task automatic test_alu_raw();
    logic [4:0] rd_v  [4] = '{5'd5, 5'd0, 5'd5, 5'd5};
    logic [4:0] rs1_v [4] = '{5'd5, 5'd0, 5'd5, 5'd5};
    logic [4:0] rs2_v [4] = '{5'd3, 5'd0, 5'd5, 5'd5};
    logic       u1_v  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_v [4] = '{8'b0000_1000, 8'b0000_0000, 8'b0000_1100, 8'b0000_0100};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      valid_m = 1; reg_write_m = 1; load_m = 0; mem_op_m = 0; valid_e = 1;
      rd_m = rd_v[i]; rs1_e = rs1_v[i]; rs2_e = rs2_v[i];
      rs1_used_e = u1_v[i]; rs2_used_e = 1;
      #1;
      checks++;
      if (outs !== exp_v[i]) begin
        failures++;
        $display("FAIL alu_raw vec%0d outs=%b expected=%b", i, outs, exp_v[i]);
      end
      $display("test_alu_raw vec%0d outs=%b", i, outs);
      tick();
    end
    clear_inputs();
  endtask

  // Load to r7 used by E's rs2; dmem_done arrives in the third cycle.
  task automatic test_load_use();
    logic [7:0] exp_v [3] = '{8'b1100_0000, 8'b1100_0001, 8'b0000_0101};
    do_reset();
    valid_m = 1; rd_m = 7; reg_write_m = 1; load_m = 1; mem_op_m = 1;
    valid_e = 1; rs2_e = 7; rs2_used_e = 1; rs1_e = 2; rs1_used_e = 1;
    for (int i = 0; i < 3; i++) begin
      dmem_done = (i == 2);
      #1;
      checks++;
      if (outs !== exp_v[i]) begin
        failures++;
        $display("FAIL load_use cyc%0d outs=%b expected=%b", i, outs, exp_v[i]);
      end
      $display("test_load_use cyc%0d outs=%b", i, outs);
      tick();
    end
    clear_inputs();
    #1;
    checks++;
    if ({outs, stall_cycles} !== {8'b0000_0000, 4'd2}) begin
      failures++;
      $display("FAIL load_use_end outs=%b cnt=%0d expected outs=00000000 cnt=2", outs, stall_cycles);
    end
  endtask

  // MDU latency 4: stall_fe for 4 cycles, bubble_m for 5.
  task automatic test_mdu();
    logic [7:0] exp;
    do_reset();
    valid_e = 1; mdu_start_e = 1;
    for (int i = 0; i < 5; i++) begin
      mdu_done = (i == 4);
      exp = (i == 0) ? 8'b1010_0000 : (i < 4) ? 8'b1010_0010 : 8'b0010_0010;
      #1;
      checks++;
      if (outs !== exp) begin
        failures++;
        $display("FAIL mdu cyc%0d outs=%b expected=%b", i, outs, exp);
      end
      $display("test_mdu cyc%0d outs=%b", i, outs);
      tick();
    end
    clear_inputs();
    #1;
    checks++;
    if ({outs, stall_cycles} !== {8'b0000_0000, 4'd4}) begin
      failures++;
      $display("FAIL mdu_end outs=%b cnt=%0d expected outs=00000000 cnt=4", outs, stall_cycles);
    end
  endtask

  // imem_busy high for 3 cycles starting with the redirect cycle; flush_fe also
  // covers the first not-busy cycle, giving 3 flushing cycles in state 3.
  task automatic test_flush();
    logic [7:0] exp_v [5] = '{8'b0001_0000, 8'b0001_0011, 8'b0001_0011,
                              8'b0001_0011, 8'b0000_0000};
    do_reset();
    valid_e = 1; flush_req = 1;
    for (int i = 0; i < 5; i++) begin
      imem_busy = (i < 3);
      flush_req = (i < 4);
      #1;
      checks++;
      if (outs !== exp_v[i]) begin
        failures++;
        $display("FAIL flush cyc%0d outs=%b expected=%b", i, outs, exp_v[i]);
      end
      $display("test_flush cyc%0d outs=%b", i, outs);
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_flush_during_stall();
    logic [7:0] exp_v [3] = '{8'b1100_0000, 8'b1100_0001, 8'b0000_0001};
    do_reset();
    valid_m = 1; mem_op_m = 1; valid_e = 1; flush_req = 1; imem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      dmem_done = (i == 2);
      #1;
      checks++;
      if (outs !== exp_v[i]) begin
        failures++;
        $display("FAIL flush_in_stall cyc%0d outs=%b expected=%b", i, outs, exp_v[i]);
      end
      $display("test_flush_during_stall cyc%0d outs=%b", i, outs);
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_concurrent_reset();
    do_reset();
    valid_e = 1; mdu_start_e = 1; flush_req = 1; imem_busy = 1;
    #1;
    checks++;
    if (outs !== 8'b1010_0000) begin
      failures++;
      $display("FAIL concurrent outs=%b expected=%b", outs, 8'b1010_0000);
    end
    tick();
    checks++;
    if ({outs, stall_cycles} !== {8'b1010_0010, 4'd1}) begin
      failures++;
      $display("FAIL concurrent_wait outs=%b cnt=%0d expected outs=10100010 cnt=1", outs, stall_cycles);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (outs !== 8'b0000_0010) begin
      failures++;
      $display("FAIL reset_in_mdu outs=%b expected=%b", outs, 8'b0000_0010);
    end
    tick();
    RST = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if ({outs, stall_cycles} !== {8'b0000_0000, 4'd0}) begin
      failures++;
      $display("FAIL after_reset outs=%b cnt=%0d expected outs=00000000 cnt=0", outs, stall_cycles);
    end
    $display("test_concurrent_reset outs=%b stall_cycles=%0d", outs, stall_cycles);
  endtask

  // A held branch must still redirect once the MDU op ahead of it completes.
  task automatic test_back_to_back();
    logic [7:0] exp_v [5] = '{8'b1010_0000, 8'b1010_0010, 8'b0010_0010,
                              8'b0001_0000, 8'b0000_0000};
    do_reset();
    valid_e = 1;
    for (int i = 0; i < 5; i++) begin
      mdu_start_e = (i < 3);
      mdu_done    = (i == 2);
      flush_req   = (i < 4);
      #1;
      checks++;
      if (outs !== exp_v[i]) begin
        failures++;
        $display("FAIL back_to_back cyc%0d outs=%b expected=%b", i, outs, exp_v[i]);
      end
      $display("test_back_to_back cyc%0d outs=%b", i, outs);
      tick();
    end
    clear_inputs();
  endtask

  // 17 stall cycles on a 4-bit counter: 16 wraps to 0, 17 leaves 1.
  task automatic test_wrap();
    do_reset();
    valid_e = 1; mdu_start_e = 1;
    for (int i = 0; i < 18; i++) begin
      mdu_done = (i == 17);
      #1;
      if (i == 16) begin
        checks++;
        if (stall_cycles !== 4'd0) begin
          failures++;
          $display("FAIL wrap_16 stall_cycles=%0d expected=0", stall_cycles);
        end
      end
      tick();
    end
    clear_inputs();
    #1;
    checks++;
    if ({state, stall_cycles} !== {2'd0, 4'd1}) begin
      failures++;
      $display("FAIL wrap_17 state=%0d cnt=%0d expected state=0 cnt=1", state, stall_cycles);
    end
    $display("test_wrap stall_cycles=%0d", stall_cycles);
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_alu_raw();
    test_load_use();
    test_mdu();
    test_flush();
    test_flush_during_stall();
    test_concurrent_reset();
    test_back_to_back();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
